// File: rtl/visited_position_counter_pkg.sv
// Shared types and helpers for the visited-position counter.
// Build option VISITED_COUNTER_CLEAR_EN enables the post-reset bitmap clear sweep.
package visited_counter_pkg;

  // Widest supported axis; module-level widths truncate from here.
  localparam int unsigned MaxPosWidth = 16;

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN, DONE} state_t;

  typedef logic [2*MaxPosWidth-1:0] addr_t;

  // {x, y} with each axis truncated to pw bits, so coordinates wrap on a torus.
  function automatic addr_t pos_to_addr(input logic [MaxPosWidth-1:0] x,
                                        input logic [MaxPosWidth-1:0] y,
                                        input int unsigned            pw);
    addr_t mask;
    mask = (addr_t'(1) << pw) - addr_t'(1);
    return ((addr_t'(x) & mask) << pw) | (addr_t'(y) & mask);
  endfunction

endpackage

// File: rtl/visited_position_counter_if.sv
// Position stream in, unique-visit report out.
// Build option VISITED_COUNTER_CLEAR_EN affects only the attached counter, not this bundle.
interface visited_position_counter_if #(
  parameter int unsigned POSITION_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH    = 16
);
  logic                      pos_change;
  logic [POSITION_WIDTH-1:0] pos_x;
  logic [POSITION_WIDTH-1:0] pos_y;
  logic                      end_of_input;
  logic                      ready;
  logic                      count_valid;
  logic [COUNT_WIDTH-1:0]    visited_count;
  logic                      count_error;

  modport master (
    output pos_change, pos_x, pos_y, end_of_input,
    input  ready, count_valid, visited_count, count_error
  );

  modport slave (
    input  pos_change, pos_x, pos_y, end_of_input,
    output ready, count_valid, visited_count, count_error
  );
endinterface

// File: rtl/visited_position_counter_bitmap_ram.sv
// 1-bit simple dual-port visited bitmap: synchronous read, read-first on collision.
// Build option VISITED_COUNTER_CLEAR_EN does not change this memory.
module visited_bitmap_ram #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data
);

  logic mem [2**ADDR_WIDTH];

  // Read and write in one process so a same-address read returns the old bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/visited_position_counter.sv
// Marks reported cells in a visited bitmap and counts first-time visits.
// Define VISITED_COUNTER_CLEAR_EN to sweep the bitmap to zero after every reset.
module visited_position_counter
  import visited_counter_pkg::*;
#(
  parameter int unsigned POSITION_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input logic                       clk,
  input logic                       reset_n,
  visited_position_counter_if.slave bus
);

  localparam int unsigned          AW        = 2 * POSITION_WIDTH;
  localparam logic [AW-1:0]        LastAddr  = '1;
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;
`ifdef VISITED_COUNTER_CLEAR_EN
  localparam state_t ResetState = CLEAR;
`else
  localparam state_t ResetState = RUN;
`endif

  state_t                 state_q, state_d;
  logic                   ready_q, count_valid_q, drain_q;
  logic                   count_error_q, count_error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [AW-1:0]          clear_addr_q;
  logic                   s1_valid_q, s1_hit_q;
  logic [AW-1:0]          s1_addr_q;

  logic          accept, rd_bit, is_new;
  logic [AW-1:0] in_addr;
  logic          wr_en, wr_data;
  logic [AW-1:0] wr_addr;

  assign in_addr = AW'(pos_to_addr(MaxPosWidth'(bus.pos_x), MaxPosWidth'(bus.pos_y),
                                   POSITION_WIDTH));
  assign accept  = ready_q & bus.pos_change;
  // A hit means the previous entry targets this cell, so the stale read is ignored.
  assign is_new  = s1_valid_q & ~rd_bit & ~s1_hit_q;

  always_comb begin
    wr_en   = is_new;
    wr_addr = s1_addr_q;
    wr_data = 1'b1;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr_q;
      wr_data = 1'b0;
    end
  end

  visited_bitmap_ram #(
    .ADDR_WIDTH (AW)
  ) u_bitmap (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (in_addr),
    .rd_data (rd_bit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clear_addr_q == LastAddr) state_d = RUN;
      RUN:     if (bus.end_of_input) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = ResetState;
    endcase
  end

  always_comb begin
    count_d       = count_q;
    count_error_d = count_error_q;
    if (bus.pos_change && !ready_q) count_error_d = 1'b1;
    if (is_new) begin
      if (count_q == CountMax) count_error_d = 1'b1;
      else                     count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ResetState;
      ready_q       <= 1'b0;
      count_valid_q <= 1'b0;
      drain_q       <= 1'b0;
      count_q       <= '0;
      count_error_q <= 1'b0;
      clear_addr_q  <= '0;
      s1_valid_q    <= 1'b0;
      s1_hit_q      <= 1'b0;
      s1_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= (state_d == RUN);
      count_valid_q <= (state_d == DONE);
      // Second DRAIN cycle; the last accepted entry commits during the first.
      drain_q       <= (state_q == DRAIN);
      count_q       <= count_d;
      count_error_q <= count_error_d;
      clear_addr_q  <= (state_q == CLEAR) ? clear_addr_q + AW'(1) : '0;
      s1_valid_q    <= accept;
      if (accept) begin
        s1_addr_q <= in_addr;
        s1_hit_q  <= s1_valid_q && (s1_addr_q == in_addr);
      end
    end
  end

  assign bus.ready         = ready_q;
  assign bus.count_valid   = count_valid_q;
  assign bus.visited_count = count_q;
  assign bus.count_error   = count_error_q;

endmodule

// File: tb/tb_visited_position_counter.sv
// Directed bench for visited_position_counter (PW=4); adapts to VISITED_COUNTER_CLEAR_EN.
module tb_visited_position_counter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  visited_position_counter_if #(.POSITION_WIDTH(4), .COUNT_WIDTH(16)) bus ();
  visited_position_counter_if #(.POSITION_WIDTH(4), .COUNT_WIDTH(2))  sbus ();

  visited_position_counter #(.POSITION_WIDTH(4), .COUNT_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  visited_position_counter #(.POSITION_WIDTH(4), .COUNT_WIDTH(2)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pos_change = 1'b0;  bus.pos_x = '0;  bus.pos_y = '0;  bus.end_of_input = 1'b0;
    sbus.pos_change = 1'b0; sbus.pos_x = '0; sbus.pos_y = '0; sbus.end_of_input = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    bus.pos_change = 1'b1;
    bus.pos_x = x;
    bus.pos_y = y;
    tick();
  endtask

  task automatic ssend(input logic [3:0] x, input logic [3:0] y);
    sbus.pos_change = 1'b1;
    sbus.pos_x = x;
    sbus.pos_y = y;
    tick();
  endtask

  task automatic eoi_and_wait3();
    bus.pos_change = 1'b0;
    bus.end_of_input = 1'b1;
    tick();
    bus.end_of_input = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bit ok;
    idle();
    reset_n = 1'b0;
    tick();
    vectors++;
    if (bus.ready !== 1'b0 || bus.count_valid !== 1'b0 || bus.visited_count !== 16'd0 ||
        bus.count_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b val=%b cnt=%0d err=%b, want 0 0 0 0",
               bus.ready, bus.count_valid, bus.visited_count, bus.count_error);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
`ifdef VISITED_COUNTER_CLEAR_EN
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, want 0 (sweeping)", bus.ready);
    end
`else
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, want 1 (no sweep)", bus.ready);
    end
`endif
    wait_ready(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_ready_timeout: got ready=%b, want 1", bus.ready);
    end
  endtask

  // (0,0),(1,0),(0,0) then end_of_input: count 2, count_valid exactly 3 cycles later.
  task automatic test_basic();
    bit ok;
    apply_reset();
    wait_ready(ok);
    send(4'h0, 4'h0);
    send(4'h1, 4'h0);
    send(4'h0, 4'h0);
    bus.pos_change = 1'b0;
    bus.end_of_input = 1'b1;
    tick();
    bus.end_of_input = 1'b0;
    vectors++;
    if (bus.ready !== 1'b0 || bus.count_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_eoi+1: got rdy=%b val=%b, want 0 0", bus.ready, bus.count_valid);
    end
    tick();
    vectors++;
    if (bus.count_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_eoi+2: got val=%b, want 0", bus.count_valid);
    end
    tick();
    vectors++;
    if (bus.count_valid !== 1'b1 || bus.visited_count !== 16'd2 || bus.count_error !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_eoi+3: got val=%b cnt=%0d err=%b, want 1 2 0",
               bus.count_valid, bus.visited_count, bus.count_error);
    end
  endtask

  // Same cell three times in a row, last one alongside end_of_input.
  task automatic test_forwarding();
    bit ok;
    apply_reset();
    wait_ready(ok);
    send(4'h3, 4'h3);
    send(4'h3, 4'h3);
    vectors++;
    if (bus.visited_count !== 16'd1) begin
      miscompares++;
      $display("FAIL fwd_latency: got cnt=%0d, want 1", bus.visited_count);
    end
    bus.end_of_input = 1'b1;
    send(4'h3, 4'h3);
    bus.pos_change = 1'b0;
    bus.end_of_input = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.count_valid !== 1'b1 || bus.visited_count !== 16'd1) begin
      miscompares++;
      $display("FAIL fwd_final: got val=%b cnt=%0d, want 1 1", bus.count_valid, bus.visited_count);
    end
  endtask

  // Corner cells, then negative coordinates that alias onto them.
  task automatic test_wrap();
    bit ok;
    apply_reset();
    wait_ready(ok);
    send(4'hF, 4'h0);
    send(4'h0, 4'hF);
    send(4'hF, 4'hF);
    send(4'h8, 4'h8);
    bus.pos_change = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.visited_count !== 16'd4) begin
      miscompares++;
      $display("FAIL wrap_corners: got cnt=%0d, want 4", bus.visited_count);
    end
    send(4'(-1), 4'h0);
    send(4'(-1), 4'(-1));
    send(4'h0, 4'(-1));
    eoi_and_wait3();
    vectors++;
    if (bus.count_valid !== 1'b1 || bus.visited_count !== 16'd4) begin
      miscompares++;
      $display("FAIL wrap_alias: got val=%b cnt=%0d, want 1 4", bus.count_valid, bus.visited_count);
    end
  endtask

`ifdef VISITED_COUNTER_CLEAR_EN
  task automatic test_drop_clear();
    bit ok;
    apply_reset();
    tick();
    tick();
    send(4'h2, 4'h2);
    bus.pos_change = 1'b0;
    vectors++;
    if (bus.count_error !== 1'b1 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_clear_err: got err=%b rdy=%b, want 1 0", bus.count_error, bus.ready);
    end
    wait_ready(ok);
    vectors++;
    if (!ok || bus.visited_count !== 16'd0) begin
      miscompares++;
      $display("FAIL drop_clear_uncounted: got ok=%b cnt=%0d, want 1 0", ok, bus.visited_count);
    end
    send(4'h2, 4'h2);
    bus.pos_change = 1'b0;
    tick();
    vectors++;
    if (bus.visited_count !== 16'd1 || bus.count_error !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_clear_recount: got cnt=%0d err=%b, want 1 1",
               bus.visited_count, bus.count_error);
    end
  endtask
`endif

  // Positions after DONE are dropped and flagged; a late end_of_input changes nothing.
  task automatic test_drop_done();
    bit ok;
    apply_reset();
    wait_ready(ok);
    vectors++;
    if (bus.count_error !== 1'b0) begin
      miscompares++;
      $display("FAIL done_err_clean: got err=%b, want 0", bus.count_error);
    end
    eoi_and_wait3();
    send(4'h6, 4'h6);
    bus.pos_change = 1'b0;
    bus.end_of_input = 1'b1;
    tick();
    bus.end_of_input = 1'b0;
    tick();
    vectors++;
    if (bus.count_error !== 1'b1 || bus.visited_count !== 16'd0 || bus.count_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL done_drop: got err=%b cnt=%0d val=%b, want 1 0 1",
               bus.count_error, bus.visited_count, bus.count_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    apply_reset();
    wait_ready(ok);
    for (int i = 4; i <= 8; i++) send(4'h4, 4'(i));
    bus.pos_change = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.visited_count !== 16'd5) begin
      miscompares++;
      $display("FAIL midrun_pre: got cnt=%0d, want 5", bus.visited_count);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (bus.visited_count !== 16'd0 || bus.count_valid !== 1'b0 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got cnt=%0d val=%b rdy=%b, want 0 0 0",
               bus.visited_count, bus.count_valid, bus.ready);
    end
    reset_n = 1'b1;
    wait_ready(ok);
`ifdef VISITED_COUNTER_CLEAR_EN
    send(4'h0, 4'h0);
`else
    send(4'h9, 4'h9);
`endif
    bus.pos_change = 1'b0;
    tick();
    vectors++;
    if (!ok || bus.visited_count !== 16'd1) begin
      miscompares++;
      $display("FAIL midrun_recount: got ok=%b cnt=%0d, want 1 1", ok, bus.visited_count);
    end
  endtask

  // COUNT_WIDTH=2 instance: five distinct cells saturate at 3 and flag an error.
  task automatic test_saturation();
    bit ok;
    apply_reset();
    wait_ready(ok);
    vectors++;
    if (sbus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_ready: got %b, want 1", sbus.ready);
    end
    for (int i = 1; i <= 3; i++) ssend(4'h1, 4'(i));
    sbus.pos_change = 1'b0;
    tick();
    tick();
    vectors++;
    if (sbus.visited_count !== 2'd3 || sbus.count_error !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_full: got cnt=%0d err=%b, want 3 0", sbus.visited_count, sbus.count_error);
    end
    ssend(4'h1, 4'h4);
    ssend(4'h1, 4'h5);
    sbus.pos_change = 1'b0;
    tick();
    tick();
    vectors++;
    if (sbus.visited_count !== 2'd3 || sbus.count_error !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_over: got cnt=%0d err=%b, want 3 1", sbus.visited_count, sbus.count_error);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_forwarding();
    test_wrap();
`ifdef VISITED_COUNTER_CLEAR_EN
    test_drop_clear();
`endif
    test_drop_done();
    test_reset_mid_run();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
